apb_mailbox: RTL and testbench

APB responder occupying the 16-byte slave window sized by `CFG_New_slave_LOG2_SIZE = 4`. The CPU pushes 32-bit words into a small FIFO. An on-chip hardware consumer drains the FIFO through a valid/ready stream. The block also exposes `CFG_HW_ID`, a status word and an interrupt enable, so firmware can identify the platform and pace its writes. It sits on the APB bridge beside the UART and other slow peripherals.

---
 rtl/apb_mailbox_pkg.sv | 21 ++
 rtl/config_target_pkg.sv | 7 +
 rtl/types_amba_pkg.sv | 19 +
 rtl/mbox_fifo.sv | 62 ++++++
 rtl/apb_mailbox.sv | 145 ++++++++++++++
 tb/tb_apb_mailbox.sv | 378 +++++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/apb_mailbox_pkg.sv
// Register map, STATUS bit positions and APB FSM states of the CPU-to-hardware mailbox.
package apb_mailbox_pkg;

    localparam logic [3:0] MBOX_DATA   = 4'h0;
    localparam logic [3:0] MBOX_STATUS = 4'h4;
    localparam logic [3:0] MBOX_HWID   = 4'h8;
    localparam logic [3:0] MBOX_CTRL   = 4'hC;

    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_UNDERFLOW = 3;
    localparam int STAT_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } mbox_state_t;

endpackage

// File: rtl/config_target_pkg.sv
// Platform identification and APB window sizing for this target.
package config_target_pkg;

    localparam logic [31:0] CFG_HW_ID               = 32'h20221101;
    localparam int          CFG_New_slave_LOG2_SIZE = 4;

endpackage

// File: rtl/types_amba_pkg.sv
// AMBA APB request/response types shared by the slow-peripheral bridge and its responders.
package types_amba_pkg;

    typedef struct packed {
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic        psel;
        logic        penable;
    } apb_in_type;

    typedef struct packed {
        logic [31:0] prdata;
        logic        pready;
        logic        pslverr;
    } apb_out_type;

endpackage

// File: rtl/mbox_fifo.sv
// Power-of-two FIFO with occupancy counter; a pop in the same cycle frees room for a push when full.
module mbox_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNTW-1:0]  o_count
);

    localparam int PTRW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic             pop_ok, push_ok;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CNTW'(DEPTH));
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        pop_ok   = i_pop & ~o_empty;
        push_ok  = i_push & (~o_full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTRW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTRW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CNTW'(1);
        else if (pop_ok && !push_ok) count_d = count_q - CNTW'(1);
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of block order.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage carries no reset; the counter alone defines which entries are meaningful.
    always_ff @(posedge i_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= i_wdata;
    end

endmodule

// File: rtl/apb_mailbox.sv
// APB mailbox: CPU pushes words over APB, a hardware consumer drains them over valid/ready.
module apb_mailbox
    import apb_mailbox_pkg::*;
    import config_target_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNTW  = $clog2(DEPTH) + 1
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  types_amba_pkg::apb_in_type i_apbi,
    output types_amba_pkg::apb_out_type o_apbo,
    output logic                       o_valid,
    output logic [31:0]                o_data,
    input  logic                       i_ready,
    output logic                       o_irq
);

    localparam int AW = CFG_New_slave_LOG2_SIZE;

    mbox_state_t     state_q;
    logic [31:0]     prdata_q;
    logic            pready_q, pslverr_q;

    logic [AW-1:0]   offs;
    logic            commit, req_err, req_ok, cpu_push, cons_pop;
    logic [31:0]     status_word, rd_word, head;
    logic            empty, full;
    logic [CNTW-1:0] count;

    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    logic            irq_ena_q, irq_ena_d;
    logic            irq_q, irq_d;
    logic            unused_paddr;

    assign unused_paddr = ^i_apbi.paddr[31:AW];

    mbox_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32),
        .CNTW  (CNTW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_push  (cpu_push),
        .i_wdata (i_apbi.pwdata),
        .i_pop   (cons_pop),
        .o_head  (head),
        .o_empty (empty),
        .o_full  (full),
        .o_count (count)
    );

    always_comb begin
        offs     = i_apbi.paddr[AW-1:0];
        commit   = (state_q == ST_ACCESS) & i_apbi.psel & i_apbi.penable;
        req_err  = (offs[1:0] != 2'b00)
                 | (i_apbi.pwrite & (offs == MBOX_DATA) & (i_apbi.pstrb != 4'hF))
                 | (i_apbi.pwrite & (offs == MBOX_HWID));
        req_ok   = commit & ~req_err;
        cpu_push = req_ok & i_apbi.pwrite & (offs == MBOX_DATA);
        cons_pop = ~empty & i_ready;

        status_word                            = '0;
        status_word[STAT_EMPTY]                = empty;
        status_word[STAT_FULL]                 = full;
        status_word[STAT_OVERFLOW]             = overflow_q;
        status_word[STAT_UNDERFLOW]            = underflow_q;
        status_word[STAT_COUNT_LSB +: CNTW]    = count;

        case (offs)
            MBOX_DATA:   rd_word = empty ? '0 : head;
            MBOX_STATUS: rd_word = status_word;
            MBOX_HWID:   rd_word = CFG_HW_ID;
            MBOX_CTRL:   rd_word = {31'd0, irq_ena_q};
            default:     rd_word = '0;
        endcase
    end

    // A full FIFO only drops the word when the consumer is not popping on the same edge.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        irq_ena_d   = irq_ena_q;
        if (cpu_push && full && !cons_pop) overflow_d = 1'b1;
        if (req_ok && !i_apbi.pwrite && (offs == MBOX_DATA) && empty) underflow_d = 1'b1;
        if (req_ok && i_apbi.pwrite && (offs == MBOX_STATUS)) begin
            if (i_apbi.pwdata[STAT_OVERFLOW])  overflow_d  = 1'b0;
            if (i_apbi.pwdata[STAT_UNDERFLOW]) underflow_d = 1'b0;
        end
        if (req_ok && i_apbi.pwrite && (offs == MBOX_CTRL)) irq_ena_d = i_apbi.pwdata[0];
        irq_d = irq_ena_q & empty;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            irq_ena_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            irq_ena_q   <= irq_ena_d;
            irq_q       <= irq_d;
        end
    end

    // Response registers are loaded at the commit edge so pready/prdata/pslverr live only in RESP.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q   <= ST_IDLE;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_apbi.psel && !i_apbi.penable) state_q <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (commit) begin
                        state_q   <= ST_RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= req_err;
                        prdata_q  <= (req_err || i_apbi.pwrite) ? '0 : rd_word;
                    end else if (!i_apbi.psel) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_apbo  = '{prdata: prdata_q, pready: pready_q, pslverr: pslverr_q};
    assign o_valid = ~empty;
    assign o_data  = head;
    assign o_irq   = irq_q;

endmodule

// File: tb/tb_apb_mailbox.sv
// Self-checking bench for apb_mailbox: directed scenarios plus randomized traffic against a queue model.
module tb_apb_mailbox;
    import types_amba_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] HW_ID = 32'h20221101;

    logic        i_clk = 1'b0;
    logic        i_nrst;
    apb_in_type  apbi;
    apb_out_type apbo;
    logic        o_valid;
    logic [31:0] o_data;
    logic        i_ready;
    logic        o_irq;

    int checks = 0;
    int errors = 0;

    // Reference model: mailbox contents as a queue plus sticky flags.
    logic [31:0] mq[$];
    bit          m_ovf, m_udf, m_irq_ena;

    always #5 i_clk = ~i_clk;

    apb_mailbox #(.DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_apbi  (apbi),
        .o_apbo  (apbo),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready),
        .o_irq   (o_irq)
    );

    function automatic void model_reset();
        mq.delete();
        m_ovf     = 1'b0;
        m_udf     = 1'b0;
        m_irq_ena = 1'b0;
    endfunction

    function automatic logic [31:0] model_status();
        int n = mq.size();
        return {23'd0, 5'(n), m_udf, m_ovf, (n == DEPTH), (n == 0)};
    endfunction

    function automatic void model_apb(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                                      input logic [3:0] strb, output logic [31:0] rd, output bit err);
        logic [3:0] off;
        off = addr[3:0];
        rd  = 32'd0;
        err = (off[1:0] != 2'b00) || (wr && off == 4'h0 && strb != 4'hF) || (wr && off == 4'h8);
        if (err) return;
        if (wr) begin
            case (off)
                4'h0: if (mq.size() == DEPTH) m_ovf = 1'b1; else mq.push_back(wd);
                4'h4: begin
                    if (wd[2]) m_ovf = 1'b0;
                    if (wd[3]) m_udf = 1'b0;
                end
                4'hC: m_irq_ena = wd[0];
                default: ;
            endcase
        end else begin
            case (off)
                4'h0: if (mq.size() == 0) m_udf = 1'b1; else rd = mq[0];
                4'h4: rd = model_status();
                4'h8: rd = HW_ID;
                4'hC: rd = {31'd0, m_irq_ena};
                default: ;
            endcase
        end
    endfunction

    // One APB transfer; entered and left at posedge+1. rdy_commit raises i_ready for the commit edge only.
    task automatic apb_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                            input logic [3:0] strb, input bit rdy_commit,
                            output logic [31:0] rd, output bit err);
        int waits;
        apbi.paddr   = addr;
        apbi.pwrite  = wr;
        apbi.pwdata  = wd;
        apbi.pstrb   = strb;
        apbi.psel    = 1'b1;
        apbi.penable = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (apbo.pready !== 1'b0) begin
            errors++;
            $display("FAIL pready_early addr=%h got=%b want=0", addr, apbo.pready);
        end
        apbi.penable = 1'b1;
        i_ready      = rdy_commit;
        waits        = 0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge i_clk); #1;
            i_ready = 1'b0;
            if (apbo.pready === 1'b1) begin
                waits = i;
                break;
            end
        end
        checks++;
        if (waits != 1) begin
            errors++;
            $display("FAIL pready_latency addr=%h got=%0d want=1 (0 = never)", addr, waits);
        end
        rd  = apbo.prdata;
        err = apbo.pslverr;
        @(posedge i_clk); #1;
        checks++;
        if (apbo !== '0) begin
            errors++;
            $display("FAIL resp_one_cycle addr=%h got=%h want=0", addr, apbo);
        end
        apbi.psel    = 1'b0;
        apbi.penable = 1'b0;
    endtask

    // Runs a transfer against DUT and model and compares the response.
    task automatic bus_op(input string tag, input logic [31:0] addr, input bit wr, input logic [31:0] wd,
                          input logic [3:0] strb, input bit rdy_commit, output logic [31:0] rd, output bit err);
        logic [31:0] exp_rd;
        bit          exp_err;
        if (rdy_commit && mq.size() != 0) void'(mq.pop_front());
        model_apb(addr, wr, wd, strb, exp_rd, exp_err);
        apb_xfer(addr, wr, wd, strb, rdy_commit, rd, err);
        checks++;
        if (rd !== exp_rd || err !== exp_err) begin
            errors++;
            $display("FAIL %s addr=%h got rd=%h err=%b want rd=%h err=%b", tag, addr, rd, err, exp_rd, exp_err);
        end
    endtask

    task automatic consume(input int n);
        for (int i = 0; i < n; i++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== mq[0]) begin
                errors++;
                $display("FAIL consume[%0d] got valid=%b data=%h want valid=1 data=%h", i, o_valid, o_data, mq[0]);
            end
            i_ready = 1'b1;
            @(posedge i_clk); #1;
            i_ready = 1'b0;
            void'(mq.pop_front());
        end
        checks++;
        if (o_valid !== (mq.size() != 0)) begin
            errors++;
            $display("FAIL valid_after_consume got=%b want=%b", o_valid, mq.size() != 0);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        bit          err;
        apbi    = '0;
        i_ready = 1'b0;
        i_nrst  = 1'b0;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        checks++;
        if (apbo !== '0 || o_valid !== 1'b0 || o_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got apbo=%h valid=%b irq=%b want 0", apbo, o_valid, o_irq);
        end
        i_nrst = 1'b1;
        model_reset();
        bus_op("hwid_read", 32'h8, 1'b0, 32'h0, 4'hF, 1'b0, rd, err);
        checks++;
        if (rd !== 32'h20221101) begin
            errors++;
            $display("FAIL hwid_value got=%h want=20221101", rd);
        end
        bus_op("status_reset", 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, rd, err);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL status_reset_value got=%h want=00000001", rd);
        end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] rd;
        bit          err;
        logic [31:0] vals[5] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55};
        foreach (vals[i]) bus_op("push", 32'h0, 1'b1, vals[i], 4'hF, 1'b0, rd, err);
        bus_op("status_full", 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, rd, err);
        checks++;
        if (rd !== 32'h46) begin
            errors++;
            $display("FAIL status_full_value got=%h want=00000046", rd);
        end
        checks++;
        if (o_data !== 32'h11) begin
            errors++;
            $display("FAIL first_head got=%h want=00000011", o_data);
        end
        consume(4);
        bus_op("clear_ovf", 32'h4, 1'b1, 32'h4, 4'hF, 1'b0, rd, err);
        bus_op("status_cleared", 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, rd, err);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        bit          err;
        for (int i = 0; i < DEPTH; i++)
            bus_op("fill", 32'h0, 1'b1, $urandom, 4'hF, 1'b0, rd, err);
        bus_op("push_with_pop", 32'h0, 1'b1, 32'h99, 4'hF, 1'b1, rd, err);
        bus_op("status_simul", 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, rd, err);
        checks++;
        if (rd !== 32'h42) begin
            errors++;
            $display("FAIL status_simul_value got=%h want=00000042", rd);
        end
        consume(DEPTH - 1);
        checks++;
        if (o_data !== 32'h99) begin
            errors++;
            $display("FAIL last_word got=%h want=00000099", o_data);
        end
        consume(1);
    endtask

    task automatic test_underflow();
        logic [31:0] rd;
        bit          err;
        bus_op("data_empty", 32'h0, 1'b0, 32'h0, 4'hF, 1'b0, rd, err);
        checks++;
        if (rd !== 32'h0 || err !== 1'b0) begin
            errors++;
            $display("FAIL empty_read got rd=%h err=%b want rd=0 err=0", rd, err);
        end
        bus_op("status_udf", 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, rd, err);
        checks++;
        if (rd !== 32'h9) begin
            errors++;
            $display("FAIL status_udf_value got=%h want=00000009", rd);
        end
        bus_op("clear_udf", 32'h4, 1'b1, 32'h8, 4'hF, 1'b0, rd, err);
        bus_op("status_udf_clr", 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, rd, err);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL status_udf_clr_value got=%h want=00000001", rd);
        end
    endtask

    task automatic test_slverr();
        logic [31:0] rd;
        bit          err;
        logic [31:0] addrs[3] = '{32'h8, 32'h2, 32'h0};
        logic [3:0]  strbs[3] = '{4'hF, 4'hF, 4'h3};
        bus_op("push_one", 32'h0, 1'b1, 32'hABCD0123, 4'hF, 1'b0, rd, err);
        foreach (addrs[i]) begin
            bus_op("err_write", addrs[i], 1'b1, 32'hDEAD0000 | 32'(i), strbs[i], 1'b0, rd, err);
            checks++;
            if (err !== 1'b1) begin
                errors++;
                $display("FAIL slverr[%0d] got=%b want=1", i, err);
            end
        end
        bus_op("status_after_err", 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, rd, err);
        checks++;
        if (rd !== 32'h10) begin
            errors++;
            $display("FAIL status_after_err_value got=%h want=00000010", rd);
        end
        consume(1);
    endtask

    task automatic test_irq_and_reset();
        logic [31:0] rd;
        bit          err;
        int          seen;
        bus_op("ctrl_on", 32'hC, 1'b1, 32'h1, 4'hF, 1'b0, rd, err);
        checks++;
        if (o_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_on got=%b want=1", o_irq);
        end
        bus_op("push_irq", 32'h0, 1'b1, 32'h5A5A5A5A, 4'hF, 1'b0, rd, err);
        checks++;
        if (o_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_off got=%b want=0", o_irq);
        end
        consume(1);
        @(posedge i_clk); #1;
        checks++;
        if (o_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_rearm got=%b want=1", o_irq);
        end
        // Reset lands during the ACCESS cycle of a DATA write.
        apbi.paddr   = 32'h0;
        apbi.pwrite  = 1'b1;
        apbi.pwdata  = 32'h77;
        apbi.pstrb   = 4'hF;
        apbi.psel    = 1'b1;
        apbi.penable = 1'b0;
        @(posedge i_clk); #1;
        apbi.penable = 1'b1;
        #2 i_nrst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk); #1;
            if (apbo.pready !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL pready_in_reset got=%0d cycles want=0", seen);
        end
        apbi.psel    = 1'b0;
        apbi.penable = 1'b0;
        i_nrst       = 1'b1;
        model_reset();
        @(posedge i_clk); #1;
        checks++;
        if (o_valid !== 1'b0 || o_irq !== 1'b0) begin
            errors++;
            $display("FAIL after_mid_reset got valid=%b irq=%b want 0 0", o_valid, o_irq);
        end
        bus_op("status_mid_reset", 32'h4, 1'b0, 32'h0, 4'hF, 1'b0, rd, err);
        bus_op("ctrl_mid_reset", 32'hC, 1'b0, 32'h0, 4'hF, 1'b0, rd, err);
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd;
        bit          err, wr;
        logic [3:0]  strb;
        logic [31:0] offs[6] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 9) < 3) begin
                if (mq.size() != 0) consume(1);
                else begin
                    @(posedge i_clk); #1;
                end
            end else begin
                addr = offs[$urandom_range(0, 5)];
                if ($urandom_range(0, 9) == 0) addr = addr | 32'($urandom_range(1, 3));
                addr = addr | ($urandom & 32'hFFFF_FFF0);
                wr   = 1'($urandom_range(0, 1));
                wd   = $urandom;
                strb = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
                bus_op("random", addr, wr, wd, strb, 1'b0, rd, err);
                checks++;
                if (o_valid !== (mq.size() != 0) || o_irq !== (m_irq_ena && mq.size() == 0)) begin
                    errors++;
                    $display("FAIL random_flags got valid=%b irq=%b want valid=%b irq=%b",
                             o_valid, o_irq, mq.size() != 0, m_irq_ena && mq.size() == 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_back_to_back();
        test_underflow();
        test_slverr();
        test_irq_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout reached");
        $fatal(1, "bench did not finish");
    end

endmodule
